// File: rtl/shot_clock_pkg.sv
// Shared types for the shot-clock controller: FSM states, BCD digit type,
// seven-segment patterns ({g,f,e,d,c,b,a}, active high) and a digit clamp.
package shot_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_EXPIRED = 2'd3
  } shot_state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic bcd_t bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/shot_clock_ctrl_if.sv
// Operator-side controls and display-side outputs of the shot clock.
// Controls are sampled on every rising clk edge; there is no ready/back-pressure.
interface shot_clock_ctrl_if;
  import shot_clock_pkg::*;

  logic        start;
  logic        pause;
  logic        reload_full;
  logic        reload_short;
  logic        load_en;
  logic [7:0]  load_val;
  logic        running;
  logic        expired;
  logic        alarm;
  bcd_t        digit_hi;
  bcd_t        digit_lo;
  logic [6:0]  seg_hi;
  logic [6:0]  seg_lo;
  logic        dp;
  shot_state_e state;

  modport master (
    output start, pause, reload_full, reload_short, load_en, load_val,
    input  running, expired, alarm, digit_hi, digit_lo, seg_hi, seg_lo, dp, state
  );

  modport slave (
    input  start, pause, reload_full, reload_short, load_en, load_val,
    output running, expired, alarm, digit_hi, digit_lo, seg_hi, seg_lo, dp, state
  );

endinterface

// File: rtl/seg7_bcd_decoder.sv
// BCD digit to active-high seven-segment pattern; non-decimal codes blank.
module seg7_bcd_decoder
  import shot_clock_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/shot_clock_ctrl.sv
// BCD shot-clock countdown with presets, load, run/hold/expired FSM and alarm.
// Define SHOT_CLOCK_TENTHS_EN for a 0.1 s tick and tenths display below 10 s.
module shot_clock_ctrl
  import shot_clock_pkg::*;
#(
  parameter int         TICK_DIV     = 50_000_000,
  parameter logic [7:0] PRESET_FULL  = 8'h24,
  parameter logic [7:0] PRESET_SHORT = 8'h14,
  parameter int         ALARM_CYCLES = 25_000_000
) (
  input  logic         clk,
  input  logic         rst,
  shot_clock_ctrl_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  shot_state_e   state_q, state_d;
  bcd_t          sec_hi_q, sec_lo_q;
  bcd_t          load_hi, load_lo, dec_hi, dec_lo;
  logic [PW-1:0] presc_q;
  logic [AW-1:0] alarm_cnt_q;
  logic          alarm_q;
  logic          any_load, counting, tick, cur_zero, last_unit, expire_tick;

  assign any_load = bus.reload_full | bus.reload_short | bus.load_en;
  // Pause and loads take the edge, so the prescaler only advances on plain RUN edges.
  assign counting = (state_q == ST_RUN) && !any_load && !bus.pause;
  assign tick     = counting && (presc_q == PRESC_LAST);

  assign dec_hi = (sec_lo_q == 4'd0) ? sec_hi_q - 4'd1 : sec_hi_q;
  assign dec_lo = (sec_lo_q == 4'd0) ? 4'd9 : sec_lo_q - 4'd1;

`ifdef SHOT_CLOCK_TENTHS_EN
  bcd_t tenths_q;
  assign cur_zero  = (sec_hi_q == 4'd0) && (sec_lo_q == 4'd0) && (tenths_q == 4'd0);
  assign last_unit = (sec_hi_q == 4'd0) && (sec_lo_q == 4'd0) && (tenths_q == 4'd1);
`else
  assign cur_zero  = (sec_hi_q == 4'd0) && (sec_lo_q == 4'd0);
  assign last_unit = (sec_hi_q == 4'd0) && (sec_lo_q == 4'd1);
`endif
  // Ticking while already at zero (a start after loading 00) also expires.
  assign expire_tick = tick && (cur_zero || last_unit);

  always_comb begin
    load_hi = bcd_clamp(bus.load_val[7:4]);
    load_lo = bcd_clamp(bus.load_val[3:0]);
    if (bus.reload_full) begin
      load_hi = PRESET_FULL[7:4];
      load_lo = PRESET_FULL[3:0];
    end else if (bus.reload_short) begin
      load_hi = PRESET_SHORT[7:4];
      load_lo = PRESET_SHORT[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (any_load) begin
      if (state_q == ST_EXPIRED) state_d = ST_IDLE;
    end else if (bus.pause) begin
      if (state_q == ST_RUN) state_d = ST_HOLD;
    end else if (bus.start && (state_q == ST_IDLE || state_q == ST_HOLD)) begin
      state_d = ST_RUN;
    end else if (expire_tick) begin
      state_d = ST_EXPIRED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_hi_q <= PRESET_FULL[7:4];
      sec_lo_q <= PRESET_FULL[3:0];
      presc_q  <= '0;
`ifdef SHOT_CLOCK_TENTHS_EN
      tenths_q <= 4'd0;
`endif
    end else if (any_load) begin
      sec_hi_q <= load_hi;
      sec_lo_q <= load_lo;
      presc_q  <= '0;
`ifdef SHOT_CLOCK_TENTHS_EN
      tenths_q <= 4'd0;
`endif
    end else if (tick) begin
      presc_q <= '0;
      if (!cur_zero) begin
`ifdef SHOT_CLOCK_TENTHS_EN
        if (tenths_q != 4'd0) begin
          tenths_q <= tenths_q - 4'd1;
        end else begin
          tenths_q <= 4'd9;
          sec_hi_q <= dec_hi;
          sec_lo_q <= dec_lo;
        end
`else
        sec_hi_q <= dec_hi;
        sec_lo_q <= dec_lo;
`endif
      end
    end else if (counting) begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Alarm runs on its own counter so loads never cut it short.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else if (expire_tick) begin
      alarm_q     <= 1'b1;
      alarm_cnt_q <= AW'(ALARM_CYCLES - 1);
    end else if (alarm_cnt_q != '0) begin
      alarm_cnt_q <= alarm_cnt_q - 1'b1;
    end else begin
      alarm_q <= 1'b0;
    end
  end

  always_comb begin
    bus.state    = state_q;
    bus.running  = (state_q == ST_RUN);
    bus.expired  = (state_q == ST_EXPIRED);
    bus.alarm    = alarm_q;
    bus.digit_hi = sec_hi_q;
    bus.digit_lo = sec_lo_q;
    bus.dp       = 1'b0;
`ifdef SHOT_CLOCK_TENTHS_EN
    if (sec_hi_q == 4'd0) begin
      bus.digit_hi = sec_lo_q;
      bus.digit_lo = tenths_q;
      bus.dp       = 1'b1;
    end
`endif
  end

  seg7_bcd_decoder u_dec_hi (.bcd(bus.digit_hi), .seg(bus.seg_hi));
  seg7_bcd_decoder u_dec_lo (.bcd(bus.digit_lo), .seg(bus.seg_lo));

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Bench for shot_clock_ctrl (TICK_DIV=4, ALARM_CYCLES=3) against an
// integer time-remaining reference model.
module tb_shot_clock_ctrl;

  localparam int TICK_DIV = 4;
  localparam int ALARM    = 3;
`ifdef SHOT_CLOCK_TENTHS_EN
  localparam int UNIT = 10;
`else
  localparam int UNIT = 1;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_EXP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shot_clock_ctrl_if ifc();

  shot_clock_ctrl #(
    .TICK_DIV(TICK_DIV), .PRESET_FULL(8'h24), .PRESET_SHORT(8'h14), .ALARM_CYCLES(ALARM)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time remaining in ticks, phase = RUN edges since last tick.
  int m_units, m_state, m_phase, m_alarm_left;

  logic [25:0] obs;
  logic [7:0]  digits;
  logic [25:0] exp_q[$];
  assign obs    = {ifc.running, ifc.expired, ifc.alarm, ifc.dp,
                   ifc.digit_hi, ifc.digit_lo, ifc.seg_hi, ifc.seg_lo};
  assign digits = {ifc.digit_hi, ifc.digit_lo};

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic int clamp9(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  function automatic logic [25:0] exp_vec();
    int secs, hi, lo;
    logic r, e, a, d;
    secs = m_units / UNIT;
    if (UNIT == 10 && secs < 10) begin
      hi = secs; lo = m_units % 10; d = 1'b1;
    end else begin
      hi = secs / 10; lo = secs % 10; d = 1'b0;
    end
    r = (m_state == M_RUN);
    e = (m_state == M_EXP);
    a = (m_alarm_left > 0);
    return {r, e, a, d, 4'(hi), 4'(lo), seg_of(hi), seg_of(lo)};
  endfunction

  function automatic void model_edge(input logic r, s, p, rf, rs, le, input logic [7:0] lv);
    logic expire;
    expire = 1'b0;
    if (r) begin
      m_units = 24 * UNIT; m_state = M_IDLE; m_phase = 0; m_alarm_left = 0;
      return;
    end
    if (rf || rs || le) begin
      if (rf)      m_units = 24 * UNIT;
      else if (rs) m_units = 14 * UNIT;
      else         m_units = (clamp9(int'(lv[7:4])) * 10 + clamp9(int'(lv[3:0]))) * UNIT;
      m_phase = 0;
      if (m_state == M_EXP) m_state = M_IDLE;
    end else if (p) begin
      if (m_state == M_RUN) m_state = M_HOLD;
    end else if (m_state == M_RUN) begin
      m_phase++;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        if (m_units > 0) m_units--;
        if (m_units == 0) begin
          m_state = M_EXP;
          expire  = 1'b1;
        end
      end
    end else if (s && (m_state == M_IDLE || m_state == M_HOLD)) begin
      m_state = M_RUN;
    end
    if (expire) m_alarm_left = ALARM;
    else if (m_alarm_left > 0) m_alarm_left--;
  endfunction

  // Drive one edge of inputs, advance the model, sample 1 ns after the edge.
  task automatic cycle(input logic r, s, p, rf, rs, le, input logic [7:0] lv);
    rst = r;
    ifc.start = s; ifc.pause = p; ifc.reload_full = rf;
    ifc.reload_short = rs; ifc.load_en = le; ifc.load_val = lv;
    @(posedge clk);
    model_edge(r, s, p, rf, rs, le, lv);
    #1;
    rst = 1'b0;
    ifc.start = 1'b0; ifc.pause = 1'b0; ifc.reload_full = 1'b0;
    ifc.reload_short = 1'b0; ifc.load_en = 1'b0;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
    n_checks++;
    if (obs !== {4'b0000, 8'h24, 7'h5B, 7'h66}) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=%h", obs, {4'b0000, 8'h24, 7'h5B, 7'h66});
    end
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_countdown();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if (ifc.running !== 1'b1) begin
      n_fail++; $display("FAIL start_running got=%b want=1", ifc.running);
    end
    for (int i = 1; i <= 99; i++) begin
      idle_cycle();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL countdown_edge%0d got=%h want=%h", i, obs, exp_vec());
      end
      if (i == 3 || i == 4 || i == 20) begin
        n_checks++;
        if (digits !== ((i == 3) ? 8'h24 : (i == 4) ? 8'h23 : 8'h19)) begin
          n_fail++; $display("FAIL countdown_digits_edge%0d got=%h", i, digits);
        end
      end
      if (i == 95 || i == 96 || i == 98 || i == 99) begin
        n_checks++;
        if ({ifc.expired, ifc.alarm, digits} !==
            ((i == 95) ? {2'b00, 8'h01} : (i == 99) ? {2'b10, 8'h00} : {2'b11, 8'h00})) begin
          n_fail++; $display("FAIL expiry_edge%0d got exp=%b alarm=%b digits=%h",
                             i, ifc.expired, ifc.alarm, digits);
        end
      end
    end
  endtask

  task automatic test_pause_resume();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (18) idle_cycle();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if ({ifc.running, digits} !== {1'b0, 8'h20}) begin
      n_fail++; $display("FAIL pause_enter got run=%b digits=%h want run=0 digits=20", ifc.running, digits);
    end
    for (int i = 0; i < 10; i++) begin
      idle_cycle();
      n_checks++;
      if (obs !== exp_vec() || digits !== 8'h20) begin
        n_fail++; $display("FAIL hold_frozen%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    idle_cycle();
    n_checks++;
    if (digits !== 8'h20) begin
      n_fail++; $display("FAIL resume_phase1 got=%h want=20", digits);
    end
    idle_cycle();
    n_checks++;
    if (digits !== 8'h19 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL resume_phase2 got=%h want=19 model=%h", digits, exp_vec());
    end
  endtask

  task automatic test_reload();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
    repeat (9) idle_cycle();
    n_checks++;
    if ({ifc.running, digits} !== {1'b1, 8'h07}) begin
      n_fail++; $display("FAIL reach_07 got run=%b digits=%h", ifc.running, digits);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if ({ifc.running, digits} !== {1'b1, 8'h14}) begin
      n_fail++; $display("FAIL reload_short got run=%b digits=%h want run=1 digits=14", ifc.running, digits);
    end
    for (int i = 1; i <= 4; i++) begin
      idle_cycle();
      n_checks++;
      if (digits !== ((i < 4) ? 8'h14 : 8'h13)) begin
        n_fail++; $display("FAIL reload_next_dec%0d got=%h", i, digits);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
    n_checks++;
    if (digits !== 8'h24 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL full_over_load got=%h want=24", digits);
    end
  endtask

  task automatic test_clamp();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3);
    n_checks++;
    if ({digits, ifc.seg_hi, ifc.seg_lo} !== {8'h93, 7'b1101111, 7'b1001111}) begin
      n_fail++; $display("FAIL clamp_a3 got digits=%h seg_hi=%b seg_lo=%b", digits, ifc.seg_hi, ifc.seg_lo);
    end
  endtask

  task automatic test_expired();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    repeat (4) idle_cycle();
    n_checks++;
    if ({ifc.expired, ifc.alarm, digits} !== {2'b11, 8'h00}) begin
      n_fail++; $display("FAIL expire_from_01 got exp=%b alarm=%b digits=%h", ifc.expired, ifc.alarm, digits);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if ({ifc.expired, ifc.running} !== 2'b10) begin
      n_fail++; $display("FAIL start_in_expired got exp=%b run=%b", ifc.expired, ifc.running);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if ({ifc.expired, ifc.running, ifc.alarm, digits} !== {3'b001, 8'h24}) begin
      n_fail++; $display("FAIL reload_from_expired got=%h want exp=0 run=0 alarm=1 digits=24", obs);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      idle_cycle();
      n_checks++;
      if (ifc.expired !== (i == 4) || obs !== exp_vec()) begin
        n_fail++; $display("FAIL start_from_00_edge%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_tenths();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 400; i++) begin
      idle_cycle();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL tenths_edge%0d got=%h want=%h", i, obs, exp_vec());
      end
      if (i == 4) begin
        n_checks++;
        if ({digits, ifc.dp} !== {8'h99, 1'b1}) begin
          n_fail++; $display("FAIL tenths_first got digits=%h dp=%b want 99/1", digits, ifc.dp);
        end
      end
      if (i == 399 || i == 400) begin
        n_checks++;
        if (ifc.expired !== (i == 400)) begin
          n_fail++; $display("FAIL tenths_expiry_edge%0d got=%b", i, ifc.expired);
        end
      end
    end
  endtask

  task automatic test_random();
    logic r, s, p, rf, rs, le;
    logic [7:0] lv;
    logic [25:0] want;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      rf = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 59) == 0);
      le = ($urandom_range(0, 39) == 0);
      p  = ($urandom_range(0, 14) == 0);
      s  = ($urandom_range(0, 7) == 0);
      lv = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      cycle(r, s, p, rf, rs, le, lv);
      exp_q.push_back(exp_vec());
      want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL random_cycle%0d got=%h want=%h", i, obs, want);
      end
    end
  endtask

  initial begin
    ifc.start = 1'b0; ifc.pause = 1'b0; ifc.reload_full = 1'b0;
    ifc.reload_short = 1'b0; ifc.load_en = 1'b0; ifc.load_val = 8'h00;
    m_units = 24 * UNIT; m_state = M_IDLE; m_phase = 0; m_alarm_left = 0;
    test_reset();
`ifdef SHOT_CLOCK_TENTHS_EN
    test_tenths();
`else
    test_countdown();
    test_pause_resume();
    test_reload();
    test_clamp();
    test_expired();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
